prime_checker_seq: RTL and testbench

Sequential trial-division primality tester. Accepts one candidate number over a valid/ready input channel and iterates divisors 2, 3, 4, ... one per clock. Returns a prime/composite verdict plus the smallest divisor over a valid/ready output channel. It is the consumer-side counterpart to the team's prime-list generator: that block emits primes, this one tests arbitrary numbers.

---
 rtl/prime_checker_seq_if.sv | 35 +++
 rtl/prime_checker_seq.sv | 106 ++++++++++
 tb/tb_prime_checker_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/prime_checker_seq_if.sv
// Handshake bundle for prime_checker_seq: candidate input channel and verdict output channel.
interface prime_checker_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic             out_is_prime;
    logic [WIDTH-1:0] out_divisor;

    modport master (
        output in_valid,
        input  in_ready,
        output in_num,
        input  out_valid,
        output out_ready,
        input  out_num,
        input  out_is_prime,
        input  out_divisor
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_num,
        output out_valid,
        input  out_ready,
        output out_num,
        output out_is_prime,
        output out_divisor
    );
endinterface

// File: rtl/prime_checker_seq.sv
// Sequential trial-division primality tester, one divisor per clock.
// Optional macro PRIME_LEGACY_01_EN: report 0 and 1 as prime, matching the generator listing.
module prime_checker_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prime_checker_seq_if.slave   bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               prime_q, prime_d;
    logic [WIDTH-1:0]   div_q, div_d;

    logic [2*WIDTH-1:0] dSq;
    logic [2*WIDTH-1:0] nExt;
    logic [WIDTH-1:0]   rem;
    logic               smallPrime;

    // Square at double width so the d*d > n test never overflows.
    assign dSq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign nExt = {{WIDTH{1'b0}}, n_q};
    assign rem  = n_q % d_q;

`ifdef PRIME_LEGACY_01_EN
    assign smallPrime = 1'b1;
`else
    assign smallPrime = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= WIDTH'(2);
            prime_q <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            prime_q <= prime_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        prime_d = prime_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    n_d     = bus.in_num;
                    d_d     = WIDTH'(2);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Priority: tiny n, then d past sqrt(n), then divisibility, else next d.
                if (n_q < WIDTH'(2)) begin
                    prime_d = smallPrime;
                    div_d   = '0;
                    state_d = DONE;
                end else if (dSq > nExt) begin
                    prime_d = 1'b1;
                    div_d   = '0;
                    state_d = DONE;
                end else if (rem == '0) begin
                    prime_d = 1'b0;
                    div_d   = d_q;
                    state_d = DONE;
                end else begin
                    d_d = d_q + WIDTH'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_num      = n_q;
    assign bus.out_is_prime = prime_q;
    assign bus.out_divisor  = div_q;
    assign busy             = (state_q == CHECK);

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq: vector table, backpressure, mid-check reset and a 2..50 stream.
module tb_prime_checker_seq;

    localparam int WIDTH = 8;

`ifdef PRIME_LEGACY_01_EN
    localparam logic SMALL_PRIME = 1'b1;
`else
    localparam logic SMALL_PRIME = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    prime_checker_seq_if #(.WIDTH(WIDTH)) bus ();

    prime_checker_seq #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] num;
        logic             expPrime;
        logic [WIDTH-1:0] expDiv;
        int               expLat;
    } vec_t;

    vec_t vecs[12];

    int passCount  = 0;
    int checkCount = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic refIsPrime(input int n);
        if (n < 2) return SMALL_PRIME;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic waitInReady();
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("inReadyWait", int'(bus.in_ready), 1);
    endtask

    // Accepts one candidate and leaves the bench at the negedge after the accept edge.
    task automatic acceptCandidate(input logic [WIDTH-1:0] num);
        waitInReady();
        bus.in_num   = num;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int lat, output int busyCycles);
        lat        = 0;
        busyCycles = 0;
        while (!bus.out_valid && lat < 100) begin
            if (busy) busyCycles++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int    lat;
        int    busyCycles;
        string tag;
        tag = $sformatf("n%0d", v.num);
        bus.out_ready = 1'b0;
        acceptCandidate(v.num);
        waitOutValid(lat, busyCycles);
        checkOutput({tag, "_latency"}, lat, v.expLat);
        checkOutput({tag, "_busyCycles"}, busyCycles, v.expLat);
        checkOutput({tag, "_outNum"}, int'(bus.out_num), int'(v.num));
        checkOutput({tag, "_isPrime"}, int'(bus.out_is_prime), int'(v.expPrime));
        checkOutput({tag, "_divisor"}, int'(bus.out_divisor), int'(v.expDiv));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_outValidDrop"}, int'(bus.out_valid), 0);
        checkOutput({tag, "_inReadyBack"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int  lat;
        int  busyCycles;
        int  results;
        logic stable;
        logic inReadyLow;

        vecs[0]  = '{num: 8'd97,  expPrime: 1'b1,        expDiv: 8'd0, expLat: 9};
        vecs[1]  = '{num: 8'd91,  expPrime: 1'b0,        expDiv: 8'd7, expLat: 6};
        vecs[2]  = '{num: 8'd255, expPrime: 1'b0,        expDiv: 8'd3, expLat: 2};
        vecs[3]  = '{num: 8'd4,   expPrime: 1'b0,        expDiv: 8'd2, expLat: 1};
        vecs[4]  = '{num: 8'd0,   expPrime: SMALL_PRIME, expDiv: 8'd0, expLat: 1};
        vecs[5]  = '{num: 8'd1,   expPrime: SMALL_PRIME, expDiv: 8'd0, expLat: 1};
        vecs[6]  = '{num: 8'd2,   expPrime: 1'b1,        expDiv: 8'd0, expLat: 1};
        vecs[7]  = '{num: 8'd3,   expPrime: 1'b1,        expDiv: 8'd0, expLat: 1};
        vecs[8]  = '{num: 8'd25,  expPrime: 1'b0,        expDiv: 8'd5, expLat: 4};
        vecs[9]  = '{num: 8'd49,  expPrime: 1'b0,        expDiv: 8'd7, expLat: 6};
        vecs[10] = '{num: 8'd13,  expPrime: 1'b1,        expDiv: 8'd0, expLat: 3};
        vecs[11] = '{num: 8'd121, expPrime: 1'b0,        expDiv: 8'd11, expLat: 10};

        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outValid", int'(bus.out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_outNum", int'(bus.out_num), 0);
        checkOutput("reset_divisor", int'(bus.out_divisor), 0);
        checkOutput("reset_isPrime", int'(bus.out_is_prime), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_inReady", int'(bus.in_ready), 1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
        end

        // Backpressure on 251 with a stray in_valid during the hold.
        bus.out_ready = 1'b0;
        acceptCandidate(8'd251);
        waitOutValid(lat, busyCycles);
        checkOutput("n251_latency", lat, 15);
        stable     = 1'b1;
        inReadyLow = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                bus.in_num   = 8'd7;
                bus.in_valid = 1'b1;
            end
            if (c == 9) bus.in_valid = 1'b0;
            if (!bus.out_valid || bus.out_num != 8'd251 || bus.out_is_prime != 1'b1 ||
                bus.out_divisor != 8'd0)
                stable = 1'b0;
            if (bus.in_ready) inReadyLow = 1'b0;
            @(negedge clk);
        end
        checkOutput("hold_stable", int'(stable), 1);
        checkOutput("hold_inReadyLow", int'(inReadyLow), 1);
        checkOutput("hold_outNum", int'(bus.out_num), 251);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("hold_outValidDrop", int'(bus.out_valid), 0);
        checkOutput("hold_inReadyBack", int'(bus.in_ready), 1);

        // Reset five edges into CHECK discards the candidate.
        acceptCandidate(8'd251);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset_busy", int'(busy), 0);
        checkOutput("midReset_outValid", int'(bus.out_valid), 0);
        checkOutput("midReset_outNum", int'(bus.out_num), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[10]);

        // Stream 2..50 with out_ready tied high.
        bus.out_ready = 1'b1;
        results = 0;
        for (int n = 2; n <= 50; n++) begin
            acceptCandidate(WIDTH'(n));
            waitOutValid(lat, busyCycles);
            checkOutput($sformatf("stream%0d_valid", n), int'(bus.out_valid), 1);
            checkOutput($sformatf("stream%0d_num", n), int'(bus.out_num), n);
            checkOutput($sformatf("stream%0d_prime", n), int'(bus.out_is_prime),
                        int'(refIsPrime(n)));
            if (bus.out_valid) results++;
        end
        checkOutput("stream_count", results, 49);
        bus.out_ready = 1'b0;

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
